// File: rtl/laser_multi_cover_pkg.sv
// rtl/laser_multi_cover_pkg.sv - shared FSM states and the squared-distance membership test
package laser_multi_cover_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_SEARCH,
    ST_EVAL,
    ST_NEXT,
    ST_FINISH
  } state_e;

  localparam int MAX_COORD_W = 8;
  localparam int D2_W        = 2 * MAX_COORD_W + 1;

  // Unsigned absolute differences, so circles never wrap across grid edges.
  function automatic logic in_circle(
    input logic [MAX_COORD_W-1:0] px,
    input logic [MAX_COORD_W-1:0] py,
    input logic [MAX_COORD_W-1:0] cx,
    input logic [MAX_COORD_W-1:0] cy,
    input logic [D2_W-1:0]        radius_sq
  );
    logic [D2_W-1:0] dx;
    logic [D2_W-1:0] dy;
    dx = D2_W'((px >= cx) ? px - cx : cx - px);
    dy = D2_W'((py >= cy) ? py - cy : cy - py);
    return (dx * dx + dy * dy) <= radius_sq;
  endfunction

endpackage

// File: rtl/laser_multi_cover_if.sv
// rtl/laser_multi_cover_if.sv - point-stream handshake between the source and the coverage engine
interface laser_multi_cover_if #(
  parameter int COORD_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;

  modport master (output in_valid, output x, output y, input in_ready);
  modport slave  (input in_valid, input x, input y, output in_ready);
endinterface

// File: rtl/laser_multi_cover_unit.sv
// rtl/laser_multi_cover_unit.sv - is one stored point inside the candidate or any other enabled circle
module laser_cover_unit
  import laser_multi_cover_pkg::*;
#(
  parameter int COORD_W     = 4,
  parameter int NUM_CIRCLES = 2,
  parameter int RADIUS_SQ   = 16,
  parameter int KW          = (NUM_CIRCLES > 1) ? $clog2(NUM_CIRCLES) : 1
) (
  input  logic [COORD_W-1:0]             px_i,
  input  logic [COORD_W-1:0]             py_i,
  input  logic [COORD_W-1:0]             cand_x_i,
  input  logic [COORD_W-1:0]             cand_y_i,
  input  logic [NUM_CIRCLES*COORD_W-1:0] cx_i,
  input  logic [NUM_CIRCLES*COORD_W-1:0] cy_i,
  input  logic [NUM_CIRCLES-1:0]         en_i,
  input  logic [KW-1:0]                  k_i,
  output logic                           covered_o
);
  localparam logic [D2_W-1:0] RSQ = D2_W'(RADIUS_SQ);

  always_comb begin
    covered_o = in_circle(MAX_COORD_W'(px_i), MAX_COORD_W'(py_i),
                          MAX_COORD_W'(cand_x_i), MAX_COORD_W'(cand_y_i), RSQ);
    // The circle being re-swept is represented only by the candidate.
    for (int j = 0; j < NUM_CIRCLES; j++) begin
      if (en_i[j] && (KW'(j) != k_i) &&
          in_circle(MAX_COORD_W'(px_i), MAX_COORD_W'(py_i),
                    MAX_COORD_W'(cx_i[j*COORD_W +: COORD_W]),
                    MAX_COORD_W'(cy_i[j*COORD_W +: COORD_W]), RSQ)) begin
        covered_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/laser_multi_cover.sv
// rtl/laser_multi_cover.sv - places NUM_CIRCLES circles by round-robin coordinate descent
module laser_multi_cover
  import laser_multi_cover_pkg::*;
#(
  parameter int  COORD_W     = 4,
  parameter int  NUM_PTS     = 40,
  parameter int  NUM_CIRCLES = 2,
  parameter int  RADIUS_SQ   = 16,
  parameter int  MAX_ROUNDS  = 6,
  localparam int CW          = $clog2(NUM_PTS + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  laser_multi_cover_if.slave             pt_if,
  output logic [NUM_CIRCLES*COORD_W-1:0] cx_o,
  output logic [NUM_CIRCLES*COORD_W-1:0] cy_o,
  output logic [CW-1:0]                  cover_o,
  output logic                           busy_o,
  output logic                           done_o
);
  localparam int GRID = 2 ** COORD_W;
  localparam int PW   = 2 * COORD_W;
  localparam int IW   = (NUM_PTS > 1) ? $clog2(NUM_PTS) : 1;
  localparam int KW   = (NUM_CIRCLES > 1) ? $clog2(NUM_CIRCLES) : 1;
  localparam int RW   = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
  localparam logic [PW-1:0] LAST_CAND = PW'(GRID * GRID - 1);

  logic [COORD_W-1:0]             pts_x_q [NUM_PTS];
  logic [COORD_W-1:0]             pts_y_q [NUM_PTS];
  state_e                         state_q;
  logic [IW-1:0]                  load_idx_q, pidx_q;
  logic [KW-1:0]                  k_q;
  logic [RW-1:0]                  round_q;
  logic [PW-1:0]                  cand_q, best_xy_q;
  logic [CW-1:0]                  count_q, best_q, prev_union_q;
  logic [NUM_CIRCLES*COORD_W-1:0] cx_q, cy_q, cx_d, cy_d;
  logic [NUM_CIRCLES-1:0]         en_q;
  logic                           covered;

  laser_cover_unit #(
    .COORD_W(COORD_W), .NUM_CIRCLES(NUM_CIRCLES), .RADIUS_SQ(RADIUS_SQ), .KW(KW)
  ) u_cover (
    .px_i(pts_x_q[pidx_q]), .py_i(pts_y_q[pidx_q]),
    .cand_x_i(cand_q[COORD_W-1:0]), .cand_y_i(cand_q[PW-1:COORD_W]),
    .cx_i(cx_q), .cy_i(cy_q), .en_i(en_q), .k_i(k_q), .covered_o(covered)
  );

  // Centres as they stand once circle k is committed to the best candidate.
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    cx_d[k_q*COORD_W +: COORD_W] = best_xy_q[COORD_W-1:0];
    cy_d[k_q*COORD_W +: COORD_W] = best_xy_q[PW-1:COORD_W];
  end

  assign pt_if.in_ready = (state_q == ST_LOAD);
  assign busy_o = (state_q == ST_SEARCH) || (state_q == ST_EVAL) || (state_q == ST_NEXT);
  assign done_o = (state_q == ST_FINISH);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_LOAD;
      load_idx_q   <= '0;
      pidx_q       <= '0;
      k_q          <= '0;
      round_q      <= '0;
      cand_q       <= '0;
      best_xy_q    <= '0;
      count_q      <= '0;
      best_q       <= '0;
      prev_union_q <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      en_q         <= '0;
      cx_o         <= '0;
      cy_o         <= '0;
      cover_o      <= '0;
    end else begin
      case (state_q)
        ST_LOAD: if (pt_if.in_valid) begin
          pts_x_q[load_idx_q] <= pt_if.x;
          pts_y_q[load_idx_q] <= pt_if.y;
          if (load_idx_q == IW'(NUM_PTS - 1)) begin
            state_q    <= ST_SEARCH;
            load_idx_q <= '0;
            pidx_q     <= '0;
            k_q        <= '0;
            round_q    <= '0;
            cand_q     <= '0;
            count_q    <= '0;
            best_q     <= '0;
            best_xy_q  <= '0;
            en_q       <= '0;
          end else begin
            load_idx_q <= load_idx_q + IW'(1);
          end
        end
        ST_SEARCH: begin
          count_q <= count_q + CW'(covered);
          if (pidx_q == IW'(NUM_PTS - 1)) begin
            pidx_q  <= '0;
            state_q <= ST_EVAL;
          end else begin
            pidx_q <= pidx_q + IW'(1);
          end
        end
        ST_EVAL: begin
          if (count_q > best_q) begin
            best_q    <= count_q;
            best_xy_q <= cand_q;
          end
          count_q <= '0;
          if (cand_q == LAST_CAND) begin
            state_q <= ST_NEXT;
          end else begin
            cand_q  <= cand_q + PW'(1);
            state_q <= ST_SEARCH;
          end
        end
        ST_NEXT: begin
          cx_q      <= cx_d;
          cy_q      <= cy_d;
          en_q[k_q] <= 1'b1;
          cand_q    <= '0;
          best_q    <= '0;
          best_xy_q <= '0;
          if (k_q != KW'(NUM_CIRCLES - 1)) begin
            k_q     <= k_q + KW'(1);
            state_q <= ST_SEARCH;
          end else if ((round_q != '0 && best_q <= prev_union_q) ||
                       round_q == RW'(MAX_ROUNDS - 1)) begin
            state_q <= ST_FINISH;
            cx_o    <= cx_d;
            cy_o    <= cy_d;
            cover_o <= best_q;
          end else begin
            round_q      <= round_q + RW'(1);
            prev_union_q <= best_q;
            k_q          <= '0;
            state_q      <= ST_SEARCH;
          end
        end
        ST_FINISH: begin
          state_q    <= ST_LOAD;
          load_idx_q <= '0;
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end
endmodule
